// File: rtl/calc_pkg.sv
// Shared definitions for the calc1 scheduler slice: command/response codes,
// the per-port FSM state type and a command validity helper.
package calc_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PORT_W    = 2;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;
  localparam logic [1:0] RESP_INT  = 2'd3;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_OP2,
    PS_PEND,
    PS_BUSY
  } port_state_t;

  function automatic logic cmd_valid(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// 4-way round-robin arbiter.
//   clk, rst   : clock, asynchronous active-high reset (pointer -> port 0)
//   pending    : one bit per requester waiting for service
//   advance    : grant is being taken this cycle; pointer moves past it
//   grant      : one-hot grant (combinational), first pending at/after pointer
//   grant_idx  : binary index of the granted requester
//   any        : at least one requester pending
module calc_rr_arbiter
  import calc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] pending,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    grant_idx,
  output logic                 any
);

  logic [PORT_W-1:0] ptr_q;
  logic [PORT_W-1:0] scan_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      scan_idx = ptr_q + k[PORT_W-1:0];
      if (!any && pending[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
        any             = 1'b1;
      end
    end
  end

  // Pointer wraps naturally through the 2-bit add (port 4 -> port 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && any) begin
      ptr_q <= grant_idx + PORT_W'(1);
    end
  end

endmodule

// File: rtl/calc_port_scheduler.sv
// Front-end scheduler for the calc1 datapath. Captures two-cycle requests
// (cmd+operand1, then operand2) on four ports, arbitrates one shared ALU
// round-robin, routes each result back as a one-cycle response pulse and
// forces an internal-error response if the ALU does not complete in time.
//   c_clk, reset        : clock, asynchronous active-high reset
//   reqN_cmd_in/data_in : requester channels (N=1..4)
//   out_dataN/out_respN : per-port response pulse (0/0 when idle)
//   alu_valid/cmd/op1/op2 : issue to ALU, held until done or timeout
//   alu_done/resp/result  : ALU completion strobe and result
module calc_port_scheduler
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = 5
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  output logic [31:0] out_data1,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data2,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data3,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data4,
  output logic [1:0]  out_resp4,
  output logic        alu_valid,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic        alu_done,
  input  logic [1:0]  alu_resp,
  input  logic [31:0] alu_result
);

  logic [3:0]  cmd_in  [NUM_PORTS];
  logic [31:0] data_in [NUM_PORTS];

  port_state_t state_q [NUM_PORTS];
  port_state_t state_d [NUM_PORTS];
  logic [3:0]  cmd_q   [NUM_PORTS];
  logic [31:0] op1_q   [NUM_PORTS];
  logic [31:0] op2_q   [NUM_PORTS];
  logic [1:0]  resp_q  [NUM_PORTS];
  logic [31:0] rdata_q [NUM_PORTS];

  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    grant_idx;
  logic                 grant_any;
  logic                 grant_en;
  logic                 done_hit;
  logic                 tmo_hit;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = rdata_q[0];
  assign out_data2 = rdata_q[1];
  assign out_data3 = rdata_q[2];
  assign out_data4 = rdata_q[3];

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pending[i] = (state_q[i] == PS_PEND);
    end
  end

  // A new grant is only decided while the ALU is idle; the cycle right
  // after a completion is therefore a bubble.
  assign grant_en = !alu_valid && grant_any;
  assign done_hit = alu_valid && alu_done;
  assign tmo_hit  = alu_valid && !alu_done &&
                    (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  calc_rr_arbiter u_arb (
    .clk       (c_clk),
    .rst       (reset),
    .pending   (pending),
    .advance   (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= PS_IDLE;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        PS_IDLE: if (cmd_in[i] != CMD_NONE) state_d[i] = PS_OP2;
        PS_OP2:  state_d[i] = cmd_valid(cmd_q[i]) ? PS_PEND : PS_IDLE;
        PS_PEND: if (grant_en && grant[i]) state_d[i] = PS_BUSY;
        // Only one port can be BUSY, so the shared done/timeout is its own.
        PS_BUSY: if (done_hit || tmo_hit) state_d[i] = PS_IDLE;
        default: state_d[i] = PS_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cmd_q[i] <= CMD_NONE;
        op1_q[i] <= '0;
        op2_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (state_q[i] == PS_IDLE && cmd_in[i] != CMD_NONE) begin
          cmd_q[i] <= cmd_in[i];
          op1_q[i] <= data_in[i];
        end
        if (state_q[i] == PS_OP2) begin
          op2_q[i] <= data_in[i];
        end
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        resp_q[i]  <= RESP_NONE;
        rdata_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        resp_q[i]  <= RESP_NONE;
        rdata_q[i] <= '0;
        if (state_q[i] == PS_OP2 && !cmd_valid(cmd_q[i])) begin
          resp_q[i] <= RESP_ERR;
        end else if (state_q[i] == PS_BUSY) begin
          if (done_hit) begin
            resp_q[i]  <= alu_resp;
            rdata_q[i] <= alu_result;
          end else if (tmo_hit) begin
            resp_q[i] <= RESP_INT;
          end
        end
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      alu_valid <= 1'b0;
      alu_cmd   <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
      tmo_cnt_q <= '0;
    end else if (grant_en) begin
      alu_valid <= 1'b1;
      alu_cmd   <= cmd_q[grant_idx];
      alu_op1   <= op1_q[grant_idx];
      alu_op2   <= op2_q[grant_idx];
      tmo_cnt_q <= '0;
    end else if (done_hit || tmo_hit) begin
      alu_valid <= 1'b0;
      tmo_cnt_q <= '0;
    end else if (alu_valid) begin
      tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
    end
  end

endmodule

// File: doc/calc_port_scheduler.md
Name: calc_port_scheduler

Overview:
- Front-end scheduler for the calc1 datapath: captures the two-cycle requests (cmd+operand1, then operand2) on four requester ports and queues one request per port.
- Grants a single shared ALU round-robin and routes each ALU result back to the originating port as a one-cycle out_resp/out_data pulse.
- Sits between the four req*_cmd_in/req*_data_in channels and one ALU execution unit. Adds an ALU-timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 16, cycles from ALU issue to forced error response.
- TIMEOUT_W, 5, counter width; must hold TIMEOUT_CYCLES.

Ports:
- c_clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- reqN_cmd_in  in  [0:3]  N=1..4; command: 0 none, 1 add, 2 sub, 5 shl, 6 shr, others invalid.
- reqN_data_in  in  [0:31]  N=1..4; operand1 in cmd cycle, operand2 in following cycle.
- out_dataN  out  [0:31]  N=1..4; result, valid only in the cycle out_respN != 0.
- out_respN  out  [0:1]  N=1..4; 0 none, 1 success, 2 overflow/underflow/invalid, 3 internal error (timeout).
- alu_valid  out  1  request to ALU; held high until alu_done.
- alu_cmd  out  [0:3]  command to ALU.
- alu_op1, alu_op2  out  [0:31]  operands to ALU.
- alu_done  in  1  one-cycle completion strobe from ALU.
- alu_resp  in  [0:1]  ALU response code, 1 or 2, valid with alu_done.
- alu_result  in  [0:31]  ALU result, valid with alu_done.

Behaviour:
- Reset values: all out_dataN = 0, out_respN = 0, alu_valid = 0, alu_cmd/op1/op2 = 0. Port FSMs go to IDLE, RR pointer goes to port1, timeout counter = 0.
- Per-port FSM states: IDLE, OP2, PEND, BUSY.
  - IDLE: a nonzero cmd at edge E0 latches cmd and operand1, then goes to OP2.
  - OP2: at edge E1, reqN_data_in is latched as operand2 regardless of cmd. A valid cmd goes to PEND. An invalid cmd goes to IDLE and drives out_respN=2, out_dataN=0 for exactly the cycle after E1; the ALU is not used.
  - PEND: waits for grant. BUSY: granted, waits for completion.
- Nonzero cmd while a port is in OP2/PEND/BUSY is ignored (protocol violation, no response). A cmd in the same cycle the port's response is driven is accepted (port already IDLE).
- Arbiter: when no ALU transaction is outstanding and at least one port is PEND, the first PEND port at or after the RR pointer is granted. Grant is registered, so alu_valid rises at the edge after the grant decision; the granted port goes to BUSY.
  - Earliest alu_valid: edge E2 for a lone request.
  - Pointer moves to granted+1 (wrapping 4 to 1) at grant.
- Only one ALU transaction is in flight. alu_cmd/op1/op2 are stable while alu_valid is high.
- alu_done with alu_valid high:
  - alu_valid drops at the same edge.
  - out_respN=alu_resp and out_dataN=alu_result for the BUSY port in the following cycle only.
  - Port returns to IDLE.
  - The next grant may be decided in the cycle after alu_done, i.e. there is a one-cycle bubble.
- alu_done while alu_valid is low is ignored.
- Timeout: counter starts at 0 on issue and increments each cycle alu_valid is high. When it reaches TIMEOUT_CYCLES with no alu_done:
  - alu_valid drops.
  - Port gets out_resp=3, out_data=0 for one cycle.
  - Port returns to IDLE.
  - An alu_done in that same cycle takes precedence over the timeout.
- Outputs on ports without a response that cycle are 0/0.
- Reset mid-operation: captured and pending requests are discarded with no response. A later alu_done is ignored.

Decomposition:
- Shared package calc_pkg holds:
  - command codes: CMD_NONE=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6;
  - response codes: RESP_NONE=0, RESP_OK=1, RESP_ERR=2, RESP_INT=3;
  - a cmd_valid() function;
  - the port FSM state enum.
- Natural sub-module: calc_rr_arbiter, a 4-way round-robin arbiter with pending[4] in, grant one-hot out, and pointer update on an advance strobe. The watchdog and routing stay in the top.

Test Plan:
- Port1 cmd=1 op1=0x0000_0001, op2=0x01FF_FFFF; ALU model returns resp 1 / data 0x0200_0000 three cycles after alu_valid → alu_valid at E2 with op1/op2 correct; out_resp1=1, out_data1=0x0200_0000 for one cycle; other ports 0.
- All four ports issue cmd=1 in the same cycle with distinct operands → ALU issues in order 1,2,3,4, one at a time with a one-cycle bubble. A second burst from all ports then also issues 1,2,3,4, confirming the pointer wraps.
- Port2 cmd=3, then cmd=4 in separate requests → out_resp2=2, out_data2=0 the cycle after operand2; alu_valid never rises.
- Port1 cmd=1 op1=0xFFFF_FFFF op2=1; ALU model returns resp 2 / data 0 → out_resp1=2, out_data1=0 pass-through.
- ALU model never asserts alu_done → after 16 cycles of alu_valid, out_resp=3, out_data=0, alu_valid low. A following request on another port is then served normally.
- Reset asserted while port3 is BUSY and port4 is PEND → outputs 0 immediately; a later alu_done produces no response; port1 cmd=5 op1=0x0000_0004 after reset yields ALU issue with alu_cmd=5.
